// File: rtl/keypad_pkg.sv
// Shared types, key map and row-decode helpers for the 4x4 keypad scan controller.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  // Indexed [row][col]; row 0 is rows[0], col 0 is cols[0].
  localparam logic [3:0] KEYMAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  // True when exactly one active-low row is pulled low.
  function automatic logic onehot_cold_ok(input logic [3:0] row);
    logic [3:0] act;
    act = ~row;
    return (act != 4'h0) && ((act & (act - 4'd1)) == 4'h0);
  endfunction

  // Index of the low row; only meaningful when onehot_cold_ok() held.
  function automatic logic [1:0] row_index(input logic [3:0] row);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!row[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/debounce_timer.sv
// Cycle counter shared by the scan dwell, press debounce and release debounce.
module debounce_timer #(
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W:0]   limit,
  output logic             done
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W:0]   LIM_ONE = (CNT_W + 1)'(1);

  logic [CNT_W-1:0] count;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_ONE;
    end
  end

  // limit is one bit wider so a limit of exactly 2**CNT_W still compares correctly.
  assign done = ({1'b0, count} == (limit - LIM_ONE));

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: one-cold column strobe, debounced press/release, one code per press.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES     = 24000,
  parameter int DEBOUNCE_CYCLES = 480000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held
);

  localparam logic [CNT_W:0] SCAN_LIM = (CNT_W + 1)'(SCAN_CYCLES);
  localparam logic [CNT_W:0] DEB_LIM  = (CNT_W + 1)'(DEBOUNCE_CYCLES);

  state_t     state;
  logic [1:0] col_idx;
  logic [3:0] row_lat;
  logic [3:0] sync1;
  logic [3:0] rs;
  logic       hit;
  logic       single;

  logic           cnt_clear;
  logic           cnt_en;
  logic           cnt_done;
  logic [CNT_W:0] cnt_limit;

  // Rows are raw pins, asynchronous to clk; idle (released) level is all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 4'hF;
      rs    <= 4'hF;
    end else begin
      sync1 <= rows;
      rs    <= sync1;
    end
  end

  assign hit    = (~rs != 4'h0);
  assign single = onehot_cold_ok(rs);
  assign cols   = ~(4'b0001 << col_idx);

  assign cnt_limit = (state == SCAN) ? SCAN_LIM : DEB_LIM;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
    case (state)
      SCAN: begin
        if (cnt_done) cnt_clear = 1'b1;
        else          cnt_en    = 1'b1;
      end
      DEBOUNCE: begin
        if ((rs != row_lat) || cnt_done) cnt_clear = 1'b1;
        else                             cnt_en    = 1'b1;
      end
      PRESSED: begin
        cnt_clear = 1'b1;
      end
      RELEASE: begin
        if (hit || cnt_done) cnt_clear = 1'b1;
        else                 cnt_en    = 1'b1;
      end
      default: begin
        cnt_clear = 1'b1;
      end
    endcase
  end

  debounce_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .limit  (cnt_limit),
    .done   (cnt_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= SCAN;
      col_idx   <= 2'd0;
      row_lat   <= 4'hF;
      key       <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      case (state)
        SCAN: begin
          if (cnt_done) begin
            // Multi-row hits are ghosting candidates and are skipped.
            if (hit && single) begin
              row_lat <= rs;
              state   <= DEBOUNCE;
            end else begin
              col_idx <= col_idx + 2'd1;
            end
          end
        end
        DEBOUNCE: begin
          if (rs != row_lat) begin
            col_idx <= col_idx + 2'd1;
            state   <= SCAN;
          end else if (cnt_done) begin
            key       <= KEYMAP[row_index(row_lat)][col_idx];
            key_valid <= 1'b1;
            key_held  <= 1'b1;
            state     <= PRESSED;
          end
        end
        PRESSED: begin
          if (!hit) state <= RELEASE;
        end
        RELEASE: begin
          if (hit) begin
            state <= PRESSED;
          end else if (cnt_done) begin
            col_idx  <= col_idx + 2'd1;
            key_held <= 1'b0;
            state    <= SCAN;
          end
        end
        default: begin
          state <= SCAN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with a small switch-matrix model driving rows.
module tb_keypad_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] key;
  logic       key_valid;
  logic       key_held;

  // press[r][c] closes the switch between row r and column c.
  logic [3:0] press [4] = '{default: 4'h0};
  logic       ovr_en  = 1'b0;
  logic [3:0] ovr_val = 4'hF;

  int n_cmp     = 0;
  int n_mis     = 0;
  int valid_cnt = 0;
  int v0;
  int n;

  logic [3:0] col_pat [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

  keypad_scan_ctrl #(
    .SCAN_CYCLES     (4),
    .DEBOUNCE_CYCLES (8),
    .CNT_W           (20)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rows      (rows),
    .cols      (cols),
    .key       (key),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++) rows[r] = ~|(press[r] & ~cols);
    if (ovr_en) rows = ovr_val;
  end

  always @(negedge clk) begin
    if (key_valid === 1'b1) valid_cnt++;
  end

  task automatic tick(input int cycles);
    repeat (cycles) @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic release_all();
    for (int r = 0; r < 4; r++) press[r] = 4'h0;
    ovr_en = 1'b0;
  endtask

  task automatic press_key(input int r, input int c);
    press[r][c] = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(3);
    reset = 1'b1;
  endtask

  task automatic wait_valid(input int start, output int cycles);
    cycles = start;
    while (key_valid !== 1'b1 && cycles < 200) begin
      tick(1);
      cycles++;
    end
  endtask

  initial begin
    // Reset state with idle keypad
    release_all();
    reset = 1'b0;
    tick(3);
    check("rst_cols", cols, 4'hE);
    check("rst_key", key, 4'h0);
    check("rst_valid", key_valid, 1'b0);
    check("rst_held", key_held, 1'b0);
    reset = 1'b1;

    // Idle scan: each column dwells 4 cycles
    v0 = valid_cnt;
    for (int k = 0; k < 40; k++) begin
      check($sformatf("idle_cols_k%0d", k), cols, col_pat[(k / 4) % 4]);
      tick(1);
    end
    check("idle_no_valid", valid_cnt - v0, 0);

    // Key 6 (row 1, col 2): DEBOUNCE entered at edge 12, accepted at edge 20
    release_all();
    press_key(1, 2);
    do_reset();
    v0 = valid_cnt;
    wait_valid(0, n);
    check("k6_latency", n, 20);
    check("k6_key", key, 4'h6);
    check("k6_held", key_held, 1'b1);
    check("k6_cols", cols, 4'hB);
    tick(1);
    check("k6_pulse_width", key_valid, 1'b0);
    tick(30);
    check("k6_cols_frozen", cols, 4'hB);
    check("k6_still_held", key_held, 1'b1);
    check("k6_one_valid", valid_cnt - v0, 1);

    // Press bounce on key 1: rejected at edge 9, accepted on the next pass at edge 33
    release_all();
    press_key(0, 0);
    do_reset();
    v0 = valid_cnt;
    tick(6);
    ovr_en  = 1'b1;
    ovr_val = 4'hF;
    tick(2);
    check("bnc_col_hold", cols, 4'hE);
    tick(1);
    check("bnc_rescan", cols, 4'hD);
    check("bnc_not_held", key_held, 1'b0);
    check("bnc_no_valid", valid_cnt - v0, 0);
    ovr_en = 1'b0;
    wait_valid(9, n);
    check("bnc_latency", n, 33);
    check("bnc_key", key, 4'h1);
    tick(5);
    check("bnc_one_valid", valid_cnt - v0, 1);

    // Ghosting: rows 0 and 1 both low on col 3, scan pattern unchanged
    release_all();
    press_key(0, 3);
    press_key(1, 3);
    do_reset();
    v0 = valid_cnt;
    for (int k = 0; k < 40; k++) begin
      check($sformatf("ghost_cols_k%0d", k), cols, col_pat[(k / 4) % 4]);
      tick(1);
    end
    check("ghost_no_valid", valid_cnt - v0, 0);
    check("ghost_not_held", key_held, 1'b0);

    // Key D with release bounce: final release set after edge 34, SCAN at edge 45
    release_all();
    press_key(3, 3);
    do_reset();
    v0 = valid_cnt;
    wait_valid(0, n);
    check("kd_latency", n, 24);
    check("kd_key", key, 4'hD);
    tick(5);
    check("kd_cols_frozen", cols, 4'h7);
    release_all();
    ovr_en  = 1'b1;
    ovr_val = 4'hF;
    tick(3);
    ovr_val = 4'h7;
    tick(2);
    check("rel_bounce_held", key_held, 1'b1);
    ovr_val = 4'hF;
    tick(10);
    check("rel_held_before_done", key_held, 1'b1);
    check("rel_cols_before_done", cols, 4'h7);
    tick(1);
    check("rel_held_dropped", key_held, 1'b0);
    check("rel_rescan_col0", cols, 4'hE);
    tick(4);
    check("rel_rescan_col1", cols, 4'hD);
    check("rel_one_valid", valid_cnt - v0, 1);
    check("rel_key_stable", key, 4'hD);

    // Reset during the 6th DEBOUNCE cycle of key 2 discards the press
    ovr_en = 1'b0;
    press_key(0, 1);
    v0 = valid_cnt;
    tick(10);
    check("mid_deb_cols", cols, 4'hD);
    check("mid_deb_not_held", key_held, 1'b0);
    check("mid_deb_key", key, 4'hD);
    reset = 1'b0;
    #1;
    check("mid_rst_cols", cols, 4'hE);
    check("mid_rst_key", key, 4'h0);
    check("mid_rst_valid", key_valid, 1'b0);
    check("mid_rst_held", key_held, 1'b0);
    release_all();
    tick(3);
    reset = 1'b1;
    tick(30);
    check("mid_rst_no_valid", valid_cnt - v0, 0);
    check("mid_rst_key_after", key, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
